// File: rtl/motion_bbox_tracker_if.sv
// motion_bbox_tracker_if
// Binary motion-mask pixel stream from the frame-difference stage.
// Signals:
//   per_frame_vsync  frame envelope, high for the whole frame
//   per_frame_href   line valid
//   per_frame_clken  pixel strobe
//   per_img_Bit      motion pixel, 1 = foreground
// Modports: master drives the stream, slave consumes it.
interface motion_bbox_tracker_if;
   logic per_frame_vsync;
   logic per_frame_href;
   logic per_frame_clken;
   logic per_img_Bit;

   modport master (output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit);
   modport slave  (input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit);
endinterface

// File: rtl/motion_bbox_tracker.sv
// motion_bbox_tracker
// Groups foreground pixels of a binary motion mask into up to MAX_TARGET
// bounding boxes per frame (proximity merge) and publishes the finished
// boxes once per frame, just after vsync falls.
// Ports:
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   pix_if                  slave side of the mask stream (vsync/href/clken/bit)
//   target_valid            one-cycle pulse when the result registers update
//   target_num, target_mask reported box count and per-slot valid flags
//   target_left/right       column bounds, slot k at [k*X_W +: X_W]
//   target_top/bottom       row bounds, slot k at [k*Y_W +: Y_W]
//   target_overflow         previous frame had foreground pixels with no free slot
module motion_bbox_tracker #(
   parameter int MAX_TARGET = 4,
   parameter int X_W        = 11,
   parameter int Y_W        = 10,
   parameter int MERGE_DIST = 8,
   parameter int MIN_PIXELS = 16
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   motion_bbox_tracker_if.slave      pix_if,
   output logic                      target_valid,
   output logic [3:0]                target_num,
   output logic [MAX_TARGET-1:0]     target_mask,
   output logic [MAX_TARGET*X_W-1:0] target_left,
   output logic [MAX_TARGET*X_W-1:0] target_right,
   output logic [MAX_TARGET*Y_W-1:0] target_top,
   output logic [MAX_TARGET*Y_W-1:0] target_bottom,
   output logic                      target_overflow
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACTIVE  = 2'd1,
      S_PUBLISH = 2'd2
   } state_e;

   localparam logic [X_W:0]            MD_X    = (X_W+1)'(MERGE_DIST);
   localparam logic [Y_W:0]            MD_Y    = (Y_W+1)'(MERGE_DIST);
   localparam logic [15:0]             MIN_CNT = 16'(MIN_PIXELS);
   localparam logic [X_W-1:0]          X_ONE   = X_W'(1);
   localparam logic [Y_W-1:0]          Y_ONE   = Y_W'(1);
   localparam logic [MAX_TARGET-1:0]   ONE_M   = MAX_TARGET'(1);

   state_e                  state_q, state_d;
   logic                    vsync_q, href_q;
   logic                    vs_rise_s, vs_fall_s, href_fall_s;
   logic                    frame_start_s, accept_s, pix_fg_s;
   logic [X_W-1:0]          x_q;
   logic [Y_W-1:0]          y_q;
   logic [MAX_TARGET-1:0]   occ_q, match_s, hit_oh_s, free_oh_s, rep_s;
   logic [X_W-1:0]          left_q   [MAX_TARGET];
   logic [X_W-1:0]          right_q  [MAX_TARGET];
   logic [Y_W-1:0]          top_q    [MAX_TARGET];
   logic [Y_W-1:0]          bottom_q [MAX_TARGET];
   logic [15:0]             cnt_q    [MAX_TARGET];
   logic                    ovf_q;
   logic [3:0]              num_s;

   assign vs_rise_s     = pix_if.per_frame_vsync & ~vsync_q;
   assign vs_fall_s     = ~pix_if.per_frame_vsync & vsync_q;
   assign href_fall_s   = ~pix_if.per_frame_href & href_q;
   assign frame_start_s = (state_q == S_IDLE) & vs_rise_s;
   assign accept_s      = (state_q == S_ACTIVE) & pix_if.per_frame_href
                        & pix_if.per_frame_clken & ~vs_fall_s;
   assign pix_fg_s      = accept_s & pix_if.per_img_Bit;

   // Lowest-index matching slot, and lowest-index free slot, as one-hot masks.
   assign hit_oh_s  = match_s & (~match_s + ONE_M);
   assign free_oh_s = ~occ_q & (occ_q + ONE_M);

   // Edge-detect history. vsync history resets high so a frame already in
   // progress when reset releases never looks like a fresh frame start.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vsync_q <= 1'b1;
         href_q  <= 1'b0;
      end else begin
         vsync_q <= pix_if.per_frame_vsync;
         href_q  <= pix_if.per_frame_href;
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (vs_rise_s) state_d = S_ACTIVE;
            else           state_d = S_IDLE;
         end
         S_ACTIVE: begin
            if (vs_fall_s) state_d = S_PUBLISH;
            else           state_d = S_ACTIVE;
         end
         S_PUBLISH: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Proximity match per slot (one bit wider so x = 0 cannot wrap), report
   // flags and their population count.
   always_comb begin
      match_s = '0;
      rep_s   = '0;
      num_s   = 4'd0;
      for (int k = 0; k < MAX_TARGET; k++) begin
         match_s[k] = occ_q[k]
                    && (({1'b0, x_q} + MD_X) >= {1'b0, left_q[k]})
                    && ({1'b0, x_q} <= ({1'b0, right_q[k]} + MD_X))
                    && ({1'b0, y_q} <= ({1'b0, bottom_q[k]} + MD_Y));
         rep_s[k]   = occ_q[k] && (cnt_q[k] >= MIN_CNT);
         num_s      = num_s + {3'b000, rep_s[k]};
      end
   end

   // Raster coordinates of the pixel currently on the input, saturating.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else if (frame_start_s) begin
         x_q <= '0;
         y_q <= '0;
      end else if ((state_q == S_ACTIVE) && href_fall_s) begin
         x_q <= '0;
         y_q <= (&y_q) ? y_q : (y_q + Y_ONE);
      end else if (accept_s) begin
         x_q <= (&x_q) ? x_q : (x_q + X_ONE);
      end
   end

   // Slot table: cleared at frame start, grown or allocated per foreground pixel.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         occ_q <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < MAX_TARGET; k++) begin
            left_q[k]   <= '0;
            right_q[k]  <= '0;
            top_q[k]    <= '0;
            bottom_q[k] <= '0;
            cnt_q[k]    <= 16'd0;
         end
      end else if (frame_start_s) begin
         occ_q <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < MAX_TARGET; k++) begin
            left_q[k]   <= '0;
            right_q[k]  <= '0;
            top_q[k]    <= '0;
            bottom_q[k] <= '0;
            cnt_q[k]    <= 16'd0;
         end
      end else if (pix_fg_s) begin
         // Pixels arrive in raster order, so top never moves after allocation.
         if (!(|match_s) && (&occ_q)) ovf_q <= 1'b1;
         for (int k = 0; k < MAX_TARGET; k++) begin
            if (hit_oh_s[k]) begin
               if (x_q < left_q[k])     left_q[k]   <= x_q;
               if (x_q > right_q[k])    right_q[k]  <= x_q;
               if (y_q > bottom_q[k])   bottom_q[k] <= y_q;
               if (cnt_q[k] != 16'hFFFF) cnt_q[k]   <= cnt_q[k] + 16'd1;
            end else if (!(|match_s) && free_oh_s[k]) begin
               occ_q[k]    <= 1'b1;
               left_q[k]   <= x_q;
               right_q[k]  <= x_q;
               top_q[k]    <= y_q;
               bottom_q[k] <= y_q;
               cnt_q[k]    <= 16'd1;
            end
         end
      end
   end

   // Result registers: loaded in the PUBLISH cycle, held until the next one.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         target_valid    <= 1'b0;
         target_num      <= 4'd0;
         target_mask     <= '0;
         target_left     <= '0;
         target_right    <= '0;
         target_top      <= '0;
         target_bottom   <= '0;
         target_overflow <= 1'b0;
      end else begin
         target_valid <= (state_q == S_PUBLISH);
         if (state_q == S_PUBLISH) begin
            target_mask     <= rep_s;
            target_num      <= num_s;
            target_overflow <= ovf_q;
            for (int k = 0; k < MAX_TARGET; k++) begin
               target_left[k*X_W +: X_W]   <= rep_s[k] ? left_q[k]   : '0;
               target_right[k*X_W +: X_W]  <= rep_s[k] ? right_q[k]  : '0;
               target_top[k*Y_W +: Y_W]    <= rep_s[k] ? top_q[k]    : '0;
               target_bottom[k*Y_W +: Y_W] <= rep_s[k] ? bottom_q[k] : '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_motion_bbox_tracker.sv
// tb_motion_bbox_tracker
// Directed bench for motion_bbox_tracker. dut0 uses the default parameters,
// dut1 shares the same pixel stream but reports boxes of a single pixel.
module tb_motion_bbox_tracker;
   localparam int MT = 4;
   localparam int XW = 11;
   localparam int YW = 10;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   always #5 sys_clk = ~sys_clk;

   motion_bbox_tracker_if vif();

   logic            a_valid, a_ovf, b_valid, b_ovf;
   logic [3:0]      a_num, b_num;
   logic [MT-1:0]   a_mask, b_mask;
   logic [MT*XW-1:0] a_left, a_right, b_left, b_right;
   logic [MT*YW-1:0] a_top, a_bottom, b_top, b_bottom;

   int checks   = 0;
   int failures = 0;

   motion_bbox_tracker #(.MAX_TARGET(MT), .X_W(XW), .Y_W(YW), .MERGE_DIST(8), .MIN_PIXELS(16)) dut0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_if(vif),
      .target_valid(a_valid), .target_num(a_num), .target_mask(a_mask),
      .target_left(a_left), .target_right(a_right), .target_top(a_top),
      .target_bottom(a_bottom), .target_overflow(a_ovf));

   motion_bbox_tracker #(.MAX_TARGET(MT), .X_W(XW), .Y_W(YW), .MERGE_DIST(8), .MIN_PIXELS(1)) dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_if(vif),
      .target_valid(b_valid), .target_num(b_num), .target_mask(b_mask),
      .target_left(b_left), .target_right(b_right), .target_top(b_top),
      .target_bottom(b_bottom), .target_overflow(b_ovf));

   // Foreground image of each scenario.
   function automatic logic pix(input int sc, input int x, input int y);
      case (sc)
         1: return (x >= 100 && x <= 109 && y >= 50 && y <= 59);
         2: return (y >= 20 && y <= 25 && ((x >= 10 && x <= 15) || (x >= 200 && x <= 205)));
         3: return ((x == 0 && y == 0) || (x == 7 && y == 3));
         4: return (y <= 4 && x <= 84 && (x % 20) <= 4);
         5: return ((x >= 5 && x <= 9 && y >= 2 && y <= 3) || (x >= 40 && x <= 45 && y >= 2 && y <= 6));
         default: return 1'b0;
      endcase
   endfunction

   task automatic send_lines(input int sc, input int w, input int y0, input int y1, input bit half);
      for (int y = y0; y <= y1; y++) begin
         for (int x = 0; x < w; x++) begin
            vif.per_frame_href  = 1'b1;
            vif.per_frame_clken = 1'b1;
            vif.per_img_Bit     = pix(sc, x, y);
            @(negedge sys_clk);
            if (half) begin
               vif.per_frame_clken = 1'b0;
               vif.per_img_Bit     = 1'b1;
               @(negedge sys_clk);
            end
         end
         vif.per_frame_href  = 1'b0;
         vif.per_frame_clken = 1'b0;
         vif.per_img_Bit     = 1'b0;
         repeat (2) @(negedge sys_clk);
      end
   endtask

   task automatic run_frame(input int sc, input int w, input int h, input bit half);
      vif.per_frame_vsync = 1'b1;
      repeat (3) @(negedge sys_clk);
      send_lines(sc, w, 0, h - 1, half);
      vif.per_frame_vsync = 1'b0;
   endtask

   // Waits (bounded) for the result pulse; lat counts negedges after vsync drop.
   task automatic wait_valid(output bit got, output int lat);
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge sys_clk);
         lat = i + 1;
         if (a_valid === 1'b1) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge sys_clk);
      checks++;
      if ({a_valid, a_num, a_mask, a_ovf, a_left, a_right, a_top, a_bottom} !== '0) begin
         failures++; $display("FAIL reset_dut0 got num=%0d mask=%b valid=%b exp all zero", a_num, a_mask, a_valid);
      end
      checks++;
      if ({b_valid, b_num, b_mask, b_ovf, b_left, b_right, b_top, b_bottom} !== '0) begin
         failures++; $display("FAIL reset_dut1 got num=%0d mask=%b valid=%b exp all zero", b_num, b_mask, b_valid);
      end
      sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_single_blob(input string tag);
      bit got; int lat;
      logic [MT*XW-1:0] el, er; logic [MT*YW-1:0] et, eb;
      el = {11'd0, 11'd0, 11'd0, 11'd100}; er = {11'd0, 11'd0, 11'd0, 11'd109};
      et = {10'd0, 10'd0, 10'd0, 10'd50};  eb = {10'd0, 10'd0, 10'd0, 10'd59};
      run_frame(1, 112, 62, 1'b0);
      wait_valid(got, lat);
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b exp=1", tag, got); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL %s_latency got=%0d exp=2", tag, lat); end
      checks++; if (a_num !== 4'd1) begin failures++; $display("FAIL %s_num got=%0d exp=1", tag, a_num); end
      checks++; if (a_mask !== 4'b0001) begin failures++; $display("FAIL %s_mask got=%b exp=0001", tag, a_mask); end
      checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL %s_ovf got=%b exp=0", tag, a_ovf); end
      checks++;
      if ({a_left, a_right, a_top, a_bottom} !== {el, er, et, eb}) begin
         failures++; $display("FAIL %s_boxes got=%h exp=%h", tag, {a_left, a_right, a_top, a_bottom}, {el, er, et, eb});
      end
      @(negedge sys_clk);
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL %s_pulse got=%b exp=0", tag, a_valid); end
   endtask

   // Two blobs, pixel strobe every other cycle while href stays high.
   task automatic test_two_blobs_clken();
      bit got; int lat;
      logic [MT*XW-1:0] el, er; logic [MT*YW-1:0] et, eb;
      el = {11'd0, 11'd0, 11'd200, 11'd10}; er = {11'd0, 11'd0, 11'd205, 11'd15};
      et = {10'd0, 10'd0, 10'd20, 10'd20};  eb = {10'd0, 10'd0, 10'd25, 10'd25};
      run_frame(2, 208, 28, 1'b1);
      wait_valid(got, lat);
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL two_valid got=%b exp=1", got); end
      checks++; if (a_num !== 4'd2) begin failures++; $display("FAIL two_num got=%0d exp=2", a_num); end
      checks++; if (a_mask !== 4'b0011) begin failures++; $display("FAIL two_mask got=%b exp=0011", a_mask); end
      checks++;
      if ({a_left, a_right, a_top, a_bottom} !== {el, er, et, eb}) begin
         failures++; $display("FAIL two_boxes got=%h exp=%h", {a_left, a_right, a_top, a_bottom}, {el, er, et, eb});
      end
      @(negedge sys_clk);
   endtask

   // Pixels at (0,0) and (7,3): merge across x = 0 without wrap.
   task automatic test_origin_merge();
      bit got; int lat;
      logic [MT*XW-1:0] er; logic [MT*YW-1:0] eb;
      er = {11'd0, 11'd0, 11'd0, 11'd7};
      eb = {10'd0, 10'd0, 10'd0, 10'd3};
      run_frame(3, 10, 5, 1'b0);
      wait_valid(got, lat);
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL origin_valid got=%b exp=1", got); end
      checks++; if (b_num !== 4'd1) begin failures++; $display("FAIL origin_num1 got=%0d exp=1", b_num); end
      checks++; if (b_mask !== 4'b0001) begin failures++; $display("FAIL origin_mask1 got=%b exp=0001", b_mask); end
      checks++;
      if ({b_left, b_right, b_top, b_bottom} !== {{(MT*XW){1'b0}}, er, {(MT*YW){1'b0}}, eb}) begin
         failures++; $display("FAIL origin_boxes1 got=%h exp=%h", {b_left, b_right, b_top, b_bottom}, {{(MT*XW){1'b0}}, er, {(MT*YW){1'b0}}, eb});
      end
      checks++;
      if ({a_num, a_mask} !== 8'd0) begin
         failures++; $display("FAIL origin_below_min got num=%0d mask=%b exp num=0 mask=0000", a_num, a_mask);
      end
      @(negedge sys_clk);
   endtask

   task automatic test_overflow();
      bit got; int lat;
      logic [MT*XW-1:0] el, er; logic [MT*YW-1:0] et, eb;
      el = {11'd60, 11'd40, 11'd20, 11'd0}; er = {11'd64, 11'd44, 11'd24, 11'd4};
      et = {10'd0, 10'd0, 10'd0, 10'd0};    eb = {10'd4, 10'd4, 10'd4, 10'd4};
      run_frame(4, 88, 6, 1'b0);
      wait_valid(got, lat);
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", got); end
      checks++; if (a_num !== 4'd4) begin failures++; $display("FAIL ovf_num got=%0d exp=4", a_num); end
      checks++; if (a_mask !== 4'b1111) begin failures++; $display("FAIL ovf_mask got=%b exp=1111", a_mask); end
      checks++; if (a_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", a_ovf); end
      checks++;
      if ({a_left, a_right, a_top, a_bottom} !== {el, er, et, eb}) begin
         failures++; $display("FAIL ovf_boxes got=%h exp=%h", {a_left, a_right, a_top, a_bottom}, {el, er, et, eb});
      end
      @(negedge sys_clk);
   endtask

   // 10-pixel blob is dropped from the report, 30-pixel blob kept in slot 1.
   task automatic test_min_pixels();
      bit got; int lat;
      logic [MT*XW-1:0] el, er; logic [MT*YW-1:0] et, eb;
      el = {11'd0, 11'd0, 11'd40, 11'd0}; er = {11'd0, 11'd0, 11'd45, 11'd0};
      et = {10'd0, 10'd0, 10'd2, 10'd0};  eb = {10'd0, 10'd0, 10'd6, 10'd0};
      run_frame(5, 48, 8, 1'b0);
      wait_valid(got, lat);
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL minpx_valid got=%b exp=1", got); end
      checks++; if (a_num !== 4'd1) begin failures++; $display("FAIL minpx_num got=%0d exp=1", a_num); end
      checks++; if (a_mask !== 4'b0010) begin failures++; $display("FAIL minpx_mask got=%b exp=0010", a_mask); end
      checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL minpx_ovf got=%b exp=0", a_ovf); end
      checks++;
      if ({a_left, a_right, a_top, a_bottom} !== {el, er, et, eb}) begin
         failures++; $display("FAIL minpx_boxes got=%h exp=%h", {a_left, a_right, a_top, a_bottom}, {el, er, et, eb});
      end
      @(negedge sys_clk);
   endtask

   task automatic test_midframe_reset();
      bit got; int lat;
      vif.per_frame_vsync = 1'b1;
      repeat (3) @(negedge sys_clk);
      send_lines(1, 112, 0, 54, 1'b0);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      checks++;
      if ({a_valid, a_num, a_mask, a_ovf, a_left, a_right, a_top, a_bottom} !== '0) begin
         failures++; $display("FAIL midrst_clear got num=%0d mask=%b exp num=0 mask=0000", a_num, a_mask);
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      send_lines(1, 112, 55, 61, 1'b0);
      vif.per_frame_vsync = 1'b0;
      wait_valid(got, lat);
      checks++; if (got !== 1'b0) begin failures++; $display("FAIL midrst_no_publish got=%b exp=0", got); end
   endtask

   task automatic test_empty_frame();
      bit got; int lat;
      run_frame(0, 16, 4, 1'b0);
      wait_valid(got, lat);
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL empty_valid got=%b exp=1", got); end
      checks++;
      if ({a_num, a_mask, a_ovf} !== 9'd0) begin
         failures++; $display("FAIL empty_result got num=%0d mask=%b ovf=%b exp 0", a_num, a_mask, a_ovf);
      end
      @(negedge sys_clk);
   endtask

   initial begin
      vif.per_frame_vsync = 1'b0;
      vif.per_frame_href  = 1'b0;
      vif.per_frame_clken = 1'b0;
      vif.per_img_Bit     = 1'b0;
      test_reset();
      test_single_blob("blob");
      test_two_blobs_clken();
      test_origin_merge();
      test_overflow();
      test_min_pixels();
      test_midframe_reset();
      test_single_blob("recover");
      test_empty_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
